// File: rtl/tof_frame_packer.sv
// tof_frame_packer: packs one frame of TOF hits into a header word plus hit words on a valid/ready stream.
// Optional TOF_FRAME_FILTER_EN drops 15'h7FFF out-of-range hits while collecting.
module tof_frame_packer #(
  parameter int MAX_HITS = 4,
  parameter int SEQ_W    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frm_start,
  input  logic        tof_valid,
  input  logic [14:0] tof_data,
  input  logic [1:0]  tof_num,
  input  logic        frm_end,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        frame_drop
);
  typedef enum logic [1:0] {IDLE, COLLECT, HEADER, DRAIN} state_t;
  state_t state, state_d;
  logic [2:0] hit_cnt, hit_cnt_d, rd_ptr, rd_ptr_d;
  logic [1:0] num_q, num_d;
  logic ovf, ovf_d, wr_en, keep, hs;
  logic [SEQ_W-1:0] seq, seq_d;
  logic [14:0] hit_buf [8];
  logic m_valid_d, m_last_d, busy_d, frame_drop_d;
  logic [15:0] m_data_d;
`ifdef TOF_FRAME_FILTER_EN
  assign keep = tof_data != 15'h7FFF;
`else
  assign keep = 1'b1;
`endif
  assign hs = m_valid & m_ready;
  always_comb begin
    state_d = state;
    hit_cnt_d = hit_cnt;
    rd_ptr_d = rd_ptr;
    num_d = num_q;
    ovf_d = ovf;
    seq_d = seq;
    wr_en = 1'b0;
    case (state)
      IDLE: if (frm_start) begin
        state_d = COLLECT;
        hit_cnt_d = 3'd0;
        ovf_d = 1'b0;
      end
      COLLECT: begin
        if (tof_valid && keep) begin
          wr_en = hit_cnt < 3'(MAX_HITS);
          hit_cnt_d = hit_cnt + {2'b00, wr_en};
          ovf_d = ovf | ~wr_en;
        end
        if (frm_end) begin
          num_d = tof_num;
          state_d = HEADER;
        end
      end
      HEADER: if (hs) begin
        seq_d = seq + SEQ_W'(1);
        rd_ptr_d = 3'd0;
        state_d = hit_cnt == 3'd0 ? IDLE : DRAIN;
      end
      DRAIN: if (hs) begin
        rd_ptr_d = rd_ptr + 3'd1;
        state_d = rd_ptr == hit_cnt - 3'd1 ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are computed from the next-state values
    m_valid_d = state_d == HEADER || state_d == DRAIN;
    busy_d = state_d != IDLE;
    frame_drop_d = frm_start && state != IDLE;
    m_last_d = state_d == HEADER ? hit_cnt_d == 3'd0 : state_d == DRAIN && rd_ptr_d == hit_cnt_d - 3'd1;
    m_data_d = state_d == HEADER ? {1'b1, hit_cnt_d, num_d, ovf_d, 9'(seq_d)} :
               state_d == DRAIN  ? {1'b0, hit_buf[rd_ptr_d]} : 16'h0000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hit_cnt <= 3'd0;
      rd_ptr <= 3'd0;
      num_q <= 2'd0;
      ovf <= 1'b0;
      seq <= '0;
      m_valid <= 1'b0;
      m_data <= 16'h0000;
      m_last <= 1'b0;
      busy <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state <= state_d;
      hit_cnt <= hit_cnt_d;
      rd_ptr <= rd_ptr_d;
      num_q <= num_d;
      ovf <= ovf_d;
      seq <= seq_d;
      m_valid <= m_valid_d;
      m_data <= m_data_d;
      m_last <= m_last_d;
      busy <= busy_d;
      frame_drop <= frame_drop_d;
    end
  end
  always_ff @(posedge clk) if (wr_en) hit_buf[hit_cnt] <= tof_data;
endmodule

// File: tb/tb_tof_frame_packer.sv
// tb_tof_frame_packer: directed and randomized frames checked against a queue-based frame model.
module tb_tof_frame_packer;
  localparam int MAX_HITS = 4;
`ifdef TOF_FRAME_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic frm_start = 1'b0, tof_valid = 1'b0, frm_end = 1'b0, m_ready = 1'b0;
  logic [14:0] tof_data = '0;
  logic [1:0] tof_num = '0;
  logic m_valid, m_last, busy, frame_drop;
  logic [15:0] m_data;
  int checks = 0, errors = 0, cyc = 0, exp_seq = 0;
  logic [16:0] got_q[$], exp_q[$];
  int hs_cyc[$];
  logic [14:0] hits_q[$];
  bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic hold_v = 1'b0;
  logic [16:0] hold_w = '0;

  tof_frame_packer #(.MAX_HITS(MAX_HITS), .SEQ_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .frm_start(frm_start), .tof_valid(tof_valid),
    .tof_data(tof_data), .tof_num(tof_num), .frm_end(frm_end), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  // capture accepted words and check that stalled words hold stable
  always @(negedge clk) begin
    if (rst_n && hold_v) begin
      checks++;
      assert (m_valid === 1'b1 && {m_last, m_data} === hold_w)
      else begin errors++; $error("FAIL hold_stable observed=%0h/%0b expected=%0h/1", {m_last, m_data}, m_valid, hold_w); end
    end
    if (rst_n && m_valid && m_ready) begin
      got_q.push_back({m_last, m_data});
      hs_cyc.push_back(cyc);
    end
    hold_v = rst_n && m_valid && !m_ready;
    hold_w = {m_last, m_data};
    cyc++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv); end
  endtask

  task automatic build_exp(input logic [1:0] num);
    logic [14:0] k[$];
    int cnt;
    foreach (hits_q[i]) if (!(FILT && hits_q[i] == 15'h7FFF)) k.push_back(hits_q[i]);
    cnt = k.size() > MAX_HITS ? MAX_HITS : k.size();
    exp_q.delete();
    exp_q.push_back({cnt == 0, 1'b1, 3'(cnt), num, k.size() > MAX_HITS, 9'(exp_seq)});
    for (int i = 0; i < cnt; i++) exp_q.push_back({i == cnt - 1, 1'b0, k[i]});
    exp_seq = (exp_seq + 1) % 512;
  endtask

  task automatic collect(input logic [1:0] num, input bit merge);
    int n = hits_q.size();
    got_q.delete();
    hs_cyc.delete();
    build_exp(num);
    frm_start = 1'b1;
    tick();
    frm_start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      tof_valid = 1'b1;
      tof_data = hits_q[i];
      if (merge && i == n - 1) begin frm_end = 1'b1; tof_num = num; end
      tick();
      tof_valid = 1'b0;
      if (!frm_end) repeat ($urandom_range(0, 1)) tick();
    end
    if (!frm_end) begin frm_end = 1'b1; tof_num = num; tick(); end
    frm_end = 1'b0;
    tof_num = 2'($urandom);
    chk("valid_latency", 32'(m_valid), 32'd1);
  endtask

  task automatic drain(input int rmode, input bit drop);
    int budget = 0, stage = 0;
    while (got_q.size() < exp_q.size() && budget < 300) begin
      m_ready = rmode == 1 ? 1'($urandom_range(0, 1)) : rmode == 2 ? (budget < 6 ? pat[budget] : 1'b1) : 1'b1;
      tof_valid = rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      tof_data = 15'($urandom);
      if (drop && stage == 0 && got_q.size() == 1) begin frm_start = 1'b1; stage = 1; end
      tick();
      budget++;
      if (stage == 1) begin chk("frame_drop_pulse", 32'(frame_drop), 32'd1); frm_start = 1'b0; stage = 2; end
      else if (stage == 2) begin chk("frame_drop_once", 32'(frame_drop), 32'd0); stage = 3; end
    end
    tof_valid = 1'b0;
    chk("drain_timeout", 32'(budget < 300), 32'd1);
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    if (rmode == 0 && got_q.size() == exp_q.size())
      chk("consecutive", 32'(hs_cyc[$] - hs_cyc[0]), 32'(exp_q.size() - 1));
    if (drop) chk("drop_seen", 32'(stage), 32'd3);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_drop", 32'(frame_drop), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tof_valid = 1'b1;
    frm_end = 1'b1;
    tick();
    tof_valid = 1'b0;
    frm_end = 1'b0;
    tick();
    chk("idle_ignores_busy", 32'(busy), 32'd0);
    chk("idle_ignores_valid", 32'(m_valid), 32'd0);
    hits_q = '{15'h0123, 15'h0456};
    collect(2'd2, 1'b0);
    drain(0, 1'b0);
    if (got_q.size() > 0) chk("basic_header", 32'(got_q[0]), 32'h0A800);
    hits_q.delete();
    collect(2'd0, 1'b0);
    drain(0, 1'b0);
    if (got_q.size() > 0) chk("empty_header", 32'(got_q[0]), 32'h18001);
    hits_q = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6};
    collect(2'd3, 1'b0);
    drain(0, 1'b0);
    if (got_q.size() > 0) chk("ovf_header", 32'(got_q[0]), 32'h0CE02);
    hits_q = '{15'h0010, 15'h7FFF, 15'h0020};
    collect(2'd3, 1'b0);
    drain(0, 1'b0);
    hits_q = '{15'h0ABC, 15'h0DEF};
    collect(2'd2, 1'b0);
    drain(2, 1'b0);
    hits_q = '{15'h0101, 15'h0202, 15'h0303, 15'h0404};
    collect(2'd1, 1'b0);
    drain(0, 1'b1);
    hits_q = '{15'h0AAA, 15'h0555};
    collect(2'd2, 1'b1);
    drain(0, 1'b0);
    hits_q = '{15'h0011, 15'h0022, 15'h0033};
    collect(2'd1, 1'b0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_last", 32'(m_last), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (4) tick();
    chk("no_partial_frame", 32'(got_q.size()), 32'd1);
    chk("abort_idle_valid", 32'(m_valid), 32'd0);
    exp_seq = 0;
    for (int f = 0; f < 520; f++) begin
      hits_q.delete();
      repeat ($urandom_range(0, 7)) hits_q.push_back($urandom_range(0, 5) == 0 ? 15'h7FFF : 15'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        tof_valid = 1'b1;
        tof_data = 15'($urandom);
        frm_end = 1'b1;
        tick();
        tof_valid = 1'b0;
        frm_end = 1'b0;
      end
      collect(2'($urandom), 1'($urandom_range(0, 1)));
      drain($urandom_range(0, 1), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
